// File: rtl/pc_unit.sv
// ---------------------------------------------------------------------------
// pc_unit -- program-counter unit for the RISC-V cores.
//
// Holds the fetch PC and chooses the next PC each cycle: sequential
// increment, branch, jump, trap vector or mret return. It stalls on fetch
// back-pressure, supports halt/resume and keeps the exception PC (EPC).
//
// Optional feature macro: PC_MISALIGN_TRAP_EN
//   defined   : a misaligned redirect target is not loaded. The PC goes to
//               TRAP_VEC, EPC captures the offending target, misalign pulses.
//   undefined : the target is loaded with bits [1:0] cleared, misalign
//               pulses and EPC is left unchanged.
//
// Ports
//   clk          in   1     clock, rising edge
//   reset        in   1     asynchronous reset, active-low
//   fetch_ready  in   1     imem accepts pc_out this cycle
//   stall        in   1     pipeline hold, PC does not advance
//   br_taken     in   1     conditional branch resolved taken
//   br_target    in   XLEN  branch target
//   jump         in   1     jal/jalr redirect
//   jump_target  in   XLEN  jump target
//   trap         in   1     exception/ecall, redirect to TRAP_VEC
//   trap_pc      in   XLEN  PC of the faulting instruction, captured into EPC
//   mret         in   1     return from trap, redirect to EPC
//   halt         in   1     enter HALT
//   resume       in   1     leave HALT
//   pc_out       out  XLEN  current fetch PC (registered)
//   pc_valid     out  1     pc_out is a valid fetch request (registered)
//   pc_plus_inc  out  XLEN  pc_out + INC, for link registers (combinational)
//   epc          out  XLEN  saved exception PC (registered)
//   halted       out  1     high while in HALT (registered)
//   misalign     out  1     one-cycle pulse for a misaligned redirect target
// ---------------------------------------------------------------------------
module pc_unit #(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = 32'h0000_0000,
  parameter logic [XLEN-1:0] TRAP_VEC  = 32'h0000_0100,
  parameter int unsigned     INC       = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            fetch_ready,
  input  logic            stall,
  input  logic            br_taken,
  input  logic [XLEN-1:0] br_target,
  input  logic            jump,
  input  logic [XLEN-1:0] jump_target,
  input  logic            trap,
  input  logic [XLEN-1:0] trap_pc,
  input  logic            mret,
  input  logic            halt,
  input  logic            resume,
  output logic [XLEN-1:0] pc_out,
  output logic            pc_valid,
  output logic [XLEN-1:0] pc_plus_inc,
  output logic [XLEN-1:0] epc,
  output logic            halted,
  output logic            misalign
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'b00,
    ST_RUN  = 2'b01,
    ST_HALT = 2'b10
  } state_t;

  state_t          state_r;
  state_t          state_nxt_s;
  logic [XLEN-1:0] pc_r;
  logic [XLEN-1:0] pc_nxt_s;
  logic [XLEN-1:0] epc_r;
  logic [XLEN-1:0] epc_nxt_s;
  logic [XLEN-1:0] pc_inc_s;
  logic [XLEN-1:0] tgt_s;
  logic            redirect_s;
  logic            tgt_mis_s;
  logic            mis_nxt_s;
  logic            misalign_r;
  logic            pc_valid_r;
  logic            halted_r;

  // Instruction addresses are 4-byte aligned; any set low bit is a misalign.
  function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
    return (addr[1:0] != 2'b00);
  endfunction

  // Sequential address, wraps modulo 2^XLEN.
  assign pc_inc_s    = pc_r + XLEN'(INC);
  assign pc_plus_inc = pc_inc_s;

  // Non-trap redirect request and the target it selects (mret > jump > branch).
  always_comb begin
    redirect_s = mret | jump | br_taken;
    if (mret) begin
      tgt_s = epc_r;
    end else if (jump) begin
      tgt_s = jump_target;
    end else begin
      tgt_s = br_target;
    end
    tgt_mis_s = is_misaligned(tgt_s);
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_BOOT;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next state. Any redirect outranks halt; resume outranks halt.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_BOOT: state_nxt_s = ST_RUN;
      ST_RUN: begin
        if (!trap && !redirect_s && halt && !resume) begin
          state_nxt_s = ST_HALT;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_HALT: begin
        if (resume) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_HALT;
        end
      end
      default: state_nxt_s = ST_BOOT;
    endcase
  end

  // Next PC / EPC / misalign selection for the current state.
  always_comb begin
    pc_nxt_s  = pc_r;
    epc_nxt_s = epc_r;
    mis_nxt_s = 1'b0;
    case (state_r)
      ST_RUN: begin
        if (trap) begin
          // trap wins over mret, so EPC is written here and not read.
          pc_nxt_s  = TRAP_VEC;
          epc_nxt_s = trap_pc;
        end else if (redirect_s) begin
          // Redirects ignore stall and back-pressure; the pending fetch is dropped.
          if (tgt_mis_s) begin
            mis_nxt_s = 1'b1;
`ifdef PC_MISALIGN_TRAP_EN
            pc_nxt_s  = TRAP_VEC;
            epc_nxt_s = tgt_s;
`else
            pc_nxt_s  = {tgt_s[XLEN-1:2], 2'b00};
`endif
          end else begin
            pc_nxt_s = tgt_s;
          end
        end else if ((halt && !resume) || stall || (pc_valid_r && !fetch_ready)) begin
          pc_nxt_s = pc_r;
        end else begin
          pc_nxt_s = pc_inc_s;
        end
      end
      ST_HALT: begin
        // Only trap is honoured while halted.
        if (trap) begin
          pc_nxt_s  = TRAP_VEC;
          epc_nxt_s = trap_pc;
        end else begin
          pc_nxt_s = pc_r;
        end
      end
      default: begin
        pc_nxt_s  = pc_r;
        epc_nxt_s = epc_r;
      end
    endcase
  end

  // PC and EPC registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_r  <= RESET_VEC;
      epc_r <= {XLEN{1'b0}};
    end else begin
      pc_r  <= pc_nxt_s;
      epc_r <= epc_nxt_s;
    end
  end

  // Registered status outputs, decoded from the upcoming state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_valid_r <= 1'b0;
      halted_r   <= 1'b0;
      misalign_r <= 1'b0;
    end else begin
      pc_valid_r <= (state_nxt_s == ST_RUN);
      halted_r   <= (state_nxt_s == ST_HALT);
      misalign_r <= mis_nxt_s;
    end
  end

  assign pc_out   = pc_r;
  assign epc      = epc_r;
  assign pc_valid = pc_valid_r;
  assign halted   = halted_r;
  assign misalign = misalign_r;

endmodule

// File: tb/tb_pc_unit.sv
module tb_pc_unit;

  localparam logic [31:0] TRAP_VEC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        fetch_ready = 1'b0, stall = 1'b0, br_taken = 1'b0, jump = 1'b0;
  logic        trap = 1'b0, mret = 1'b0, halt = 1'b0, resume = 1'b0;
  logic [31:0] br_target = 32'h0, jump_target = 32'h0, trap_pc = 32'h0;
  logic [31:0] pc_out, pc_plus_inc, epc;
  logic        pc_valid, halted, misalign;

  int checks = 0;
  int failures = 0;

  // Reference model: architectural PC, EPC and mode flags.
  logic [31:0] m_pc, m_epc;
  bit          m_booted, m_halted, m_mis;

  always #5 clk = ~clk;

  pc_unit #(.XLEN(32), .RESET_VEC(32'h0000_0000), .TRAP_VEC(TRAP_VEC), .INC(4)) dut (
    .clk(clk), .reset(reset), .fetch_ready(fetch_ready), .stall(stall),
    .br_taken(br_taken), .br_target(br_target), .jump(jump), .jump_target(jump_target),
    .trap(trap), .trap_pc(trap_pc), .mret(mret), .halt(halt), .resume(resume),
    .pc_out(pc_out), .pc_valid(pc_valid), .pc_plus_inc(pc_plus_inc), .epc(epc),
    .halted(halted), .misalign(misalign)
  );

  task automatic clear_inputs();
    fetch_ready = 1'b1; stall = 1'b0; br_taken = 1'b0; jump = 1'b0;
    trap = 1'b0; mret = 1'b0; halt = 1'b0; resume = 1'b0;
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_epc = 32'h0; m_booted = 1'b0; m_halted = 1'b0; m_mis = 1'b0;
  endtask

  // One clock edge of the architectural rules, applied to the current inputs.
  task automatic model_edge();
    logic [31:0] tgt;
    m_mis = 1'b0;
    if (!m_booted) begin
      m_booted = 1'b1;
    end else if (m_halted) begin
      if (trap) begin m_pc = TRAP_VEC; m_epc = trap_pc; end
      if (resume) m_halted = 1'b0;
    end else if (trap) begin
      m_pc = TRAP_VEC; m_epc = trap_pc;
    end else if (mret || jump || br_taken) begin
      tgt = mret ? m_epc : (jump ? jump_target : br_target);
      if ((tgt % 4) != 0) begin
        m_mis = 1'b1;
`ifdef PC_MISALIGN_TRAP_EN
        m_pc = TRAP_VEC; m_epc = tgt;
`else
        m_pc = tgt - (tgt % 4);
`endif
      end else begin
        m_pc = tgt;
      end
    end else if (halt && !resume) begin
      m_halted = 1'b1;
    end else if (!stall && fetch_ready) begin
      m_pc = m_pc + 32'd4;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    clear_inputs(); reset = 1'b0; model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (pc_out !== 32'h0) begin failures++; $display("FAIL reset_pc got=%h exp=%h", pc_out, 32'h0); end
    checks++; if (pc_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", pc_valid); end
    checks++; if (epc !== 32'h0) begin failures++; $display("FAIL reset_epc got=%h exp=0", epc); end
    checks++; if (halted !== 1'b0 || misalign !== 1'b0) begin failures++; $display("FAIL reset_flags halted=%b misalign=%b exp=0,0", halted, misalign); end
    @(negedge clk); reset = 1'b1;
    #1;
    checks++; if (pc_valid !== 1'b0) begin failures++; $display("FAIL boot_valid got=%b exp=0", pc_valid); end
    tick();
    checks++; if (pc_valid !== 1'b1 || pc_out !== 32'h0) begin failures++; $display("FAIL boot_to_run valid=%b pc=%h exp=1,0", pc_valid, pc_out); end
  endtask

  task automatic test_sequential();
    for (int i = 1; i <= 2; i++) begin
      tick();
      checks++; if (pc_out !== 32'(i * 4)) begin failures++; $display("FAIL seq_pc got=%h exp=%h", pc_out, 32'(i * 4)); end
    end
  endtask

  task automatic test_backpressure();
    fetch_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (pc_out !== 32'h8) begin failures++; $display("FAIL bp_hold got=%h exp=%h", pc_out, 32'h8); end
    end
    fetch_ready = 1'b1;
    tick();
    checks++; if (pc_out !== 32'hC) begin failures++; $display("FAIL bp_release got=%h exp=%h", pc_out, 32'hC); end
  endtask

  task automatic test_trap_mret();
    trap = 1'b1; trap_pc = 32'h10; jump = 1'b1; jump_target = 32'h40;
    tick();
    checks++; if (pc_out !== 32'h100 || epc !== 32'h10) begin failures++; $display("FAIL trap_over_jump pc=%h epc=%h exp=100,10", pc_out, epc); end
    clear_inputs();
    tick();
    mret = 1'b1;
    tick();
    checks++; if (pc_out !== 32'h10) begin failures++; $display("FAIL mret_pc got=%h exp=10", pc_out); end
    clear_inputs();
  endtask

  task automatic test_stall_branch();
    stall = 1'b1; br_taken = 1'b1; br_target = 32'h80;
    tick();
    checks++; if (pc_out !== 32'h80) begin failures++; $display("FAIL stall_branch got=%h exp=80", pc_out); end
    clear_inputs();
  endtask

  task automatic test_misalign();
    jump = 1'b1; jump_target = 32'h42;
    tick();
`ifdef PC_MISALIGN_TRAP_EN
    checks++; if (pc_out !== 32'h100 || epc !== 32'h42) begin failures++; $display("FAIL misalign_trap pc=%h epc=%h exp=100,42", pc_out, epc); end
`else
    checks++; if (pc_out !== 32'h40 || epc !== 32'h10) begin failures++; $display("FAIL misalign_force pc=%h epc=%h exp=40,10", pc_out, epc); end
`endif
    checks++; if (misalign !== 1'b1) begin failures++; $display("FAIL misalign_pulse got=%b exp=1", misalign); end
    clear_inputs();
    tick();
    checks++; if (misalign !== 1'b0) begin failures++; $display("FAIL misalign_clear got=%b exp=0", misalign); end
  endtask

  task automatic test_wrap();
    jump = 1'b1; jump_target = 32'hFFFF_FFFC;
    tick();
    clear_inputs();
    checks++; if (pc_out !== 32'hFFFF_FFFC || pc_plus_inc !== 32'h0) begin failures++; $display("FAIL wrap_pre pc=%h inc=%h exp=fffffffc,0", pc_out, pc_plus_inc); end
    tick();
    checks++; if (pc_out !== 32'h0) begin failures++; $display("FAIL wrap_pc got=%h exp=0", pc_out); end
  endtask

  task automatic test_halt_resume();
    jump = 1'b1; jump_target = 32'h20;
    tick();
    clear_inputs(); halt = 1'b1;
    tick();
    checks++; if (halted !== 1'b1 || pc_valid !== 1'b0 || pc_out !== 32'h20) begin failures++; $display("FAIL halt_enter halted=%b valid=%b pc=%h exp=1,0,20", halted, pc_valid, pc_out); end
    halt = 1'b0; jump = 1'b1; jump_target = 32'h60;
    tick();
    checks++; if (pc_out !== 32'h20 || halted !== 1'b1) begin failures++; $display("FAIL halt_ignore_jump pc=%h halted=%b exp=20,1", pc_out, halted); end
    jump = 1'b0; resume = 1'b1;
    tick();
    checks++; if (halted !== 1'b0 || pc_valid !== 1'b1 || pc_out !== 32'h20) begin failures++; $display("FAIL resume halted=%b valid=%b pc=%h exp=0,1,20", halted, pc_valid, pc_out); end
    resume = 1'b0;
    tick();
    checks++; if (pc_out !== 32'h24) begin failures++; $display("FAIL resume_fetch got=%h exp=24", pc_out); end
    halt = 1'b1; resume = 1'b1;
    tick();
    checks++; if (halted !== 1'b0 || pc_out !== 32'h28) begin failures++; $display("FAIL run_halt_resume halted=%b pc=%h exp=0,28", halted, pc_out); end
    resume = 1'b0;
    tick();
    resume = 1'b1;
    tick();
    checks++; if (halted !== 1'b0 || pc_out !== 32'h28) begin failures++; $display("FAIL halt_resume_together halted=%b pc=%h exp=0,28", halted, pc_out); end
    resume = 1'b0;
    tick();
    halt = 1'b0;
    checks++; if (halted !== 1'b1) begin failures++; $display("FAIL halt_reenter got=%b exp=1", halted); end
    @(negedge clk); #2; reset = 1'b0; #1;
    model_reset();
    checks++; if (pc_out !== 32'h0 || halted !== 1'b0 || pc_valid !== 1'b0 || epc !== 32'h0) begin failures++; $display("FAIL async_reset pc=%h halted=%b valid=%b epc=%h exp=0,0,0,0", pc_out, halted, pc_valid, epc); end
    @(negedge clk); reset = 1'b1;
    tick();
  endtask

  task automatic test_random();
    logic [31:0] r;
    for (int i = 0; i < 400; i++) begin
      trap        = ($urandom_range(15) == 0);
      mret        = ($urandom_range(15) == 0);
      jump        = ($urandom_range(9) == 0);
      br_taken    = ($urandom_range(7) == 0);
      halt        = ($urandom_range(15) == 0);
      resume      = ($urandom_range(5) == 0);
      stall       = ($urandom_range(4) == 0);
      fetch_ready = ($urandom_range(3) != 0);
      r = $urandom; jump_target = ($urandom_range(3) == 0) ? r : (r & 32'hFFFF_FFFC);
      r = $urandom; br_target   = ($urandom_range(3) == 0) ? r : (r & 32'hFFFF_FFFC);
      r = $urandom; trap_pc     = ($urandom_range(7) == 0) ? r : (r & 32'hFFFF_FFFC);
      tick();
      checks++; if (pc_out !== m_pc) begin failures++; $display("FAIL rand_pc cyc=%0d got=%h exp=%h", i, pc_out, m_pc); end
      checks++; if (epc !== m_epc) begin failures++; $display("FAIL rand_epc cyc=%0d got=%h exp=%h", i, epc, m_epc); end
      checks++; if (pc_valid !== (m_booted && !m_halted)) begin failures++; $display("FAIL rand_valid cyc=%0d got=%b exp=%b", i, pc_valid, m_booted && !m_halted); end
      checks++; if (halted !== m_halted) begin failures++; $display("FAIL rand_halted cyc=%0d got=%b exp=%b", i, halted, m_halted); end
      checks++; if (misalign !== m_mis) begin failures++; $display("FAIL rand_misalign cyc=%0d got=%b exp=%b", i, misalign, m_mis); end
      checks++; if (pc_plus_inc !== m_pc + 32'd4) begin failures++; $display("FAIL rand_plus_inc cyc=%0d got=%h exp=%h", i, pc_plus_inc, m_pc + 32'd4); end
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_backpressure();
    test_trap_mret();
    test_stall_branch();
    test_misalign();
    test_wrap();
    test_halt_resume();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
